// File: rtl/dma_xfer_pkg.sv
// Shared widths and FSM state encodings for the DMA copy controller.
package dma_xfer_pkg;

    localparam int unsigned DMA_DATA_WIDTH  = 512;
    localparam int unsigned DMA_ADDR_WIDTH  = 64;
    localparam int unsigned DMA_SIZE_WIDTH  = 17;
    localparam int unsigned DMA_CYCLE_WIDTH = 32;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_START = 3'd1;
    localparam state_t ST_XFER  = 3'd2;
    localparam state_t ST_WAIT  = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

endpackage

// File: rtl/dma_xfer_ctrl_if.sv
// Peripheral-side DMA signals: read/write start, read stream pop and write stream push.
interface dma_xfer_ctrl_if
    import dma_xfer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DMA_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DMA_ADDR_WIDTH,
    parameter int unsigned SIZE_WIDTH = DMA_SIZE_WIDTH
);

    logic                  dma_rd_go;
    logic [ADDR_WIDTH-1:0] dma_rd_addr;
    logic [SIZE_WIDTH-1:0] dma_rd_size;
    logic                  dma_rd_en;
    logic [DATA_WIDTH-1:0] dma_rd_data;
    logic                  dma_empty;
    logic                  dma_rd_done;
    logic                  dma_wr_go;
    logic [ADDR_WIDTH-1:0] dma_wr_addr;
    logic [SIZE_WIDTH-1:0] dma_wr_size;
    logic                  dma_wr_en;
    logic [DATA_WIDTH-1:0] dma_wr_data;
    logic                  dma_full;
    logic                  dma_wr_done;

    modport master (
        output dma_rd_go, dma_rd_addr, dma_rd_size, dma_rd_en,
        input  dma_rd_data, dma_empty, dma_rd_done,
        output dma_wr_go, dma_wr_addr, dma_wr_size, dma_wr_en, dma_wr_data,
        input  dma_full, dma_wr_done
    );

    modport slave (
        input  dma_rd_go, dma_rd_addr, dma_rd_size, dma_rd_en,
        output dma_rd_data, dma_empty, dma_rd_done,
        input  dma_wr_go, dma_wr_addr, dma_wr_size, dma_wr_en, dma_wr_data,
        output dma_full, dma_wr_done
    );

endinterface

// File: rtl/dma_xfer_stage.sv
// One-entry pipeline register between the read and write streams.
module dma_xfer_stage
    import dma_xfer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DMA_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_ld,
    input  logic                  i_clr,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;

    // A load wins over a clear so a same-cycle pop/push keeps the entry full.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_ld) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/dma_xfer_ctrl.sv
// Sequences one memory-to-memory DMA copy and reports done plus elapsed cycles to MMIO.
module dma_xfer_ctrl
    import dma_xfer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DMA_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH  = DMA_ADDR_WIDTH,
    parameter int unsigned SIZE_WIDTH  = DMA_SIZE_WIDTH,
    parameter int unsigned CYCLE_WIDTH = DMA_CYCLE_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_go,
    input  logic [ADDR_WIDTH-1:0]  i_src_addr,
    input  logic [ADDR_WIDTH-1:0]  i_dst_addr,
    input  logic [SIZE_WIDTH-1:0]  i_size,
    output logic                   o_done,
    output logic                   o_busy,
    output logic [CYCLE_WIDTH-1:0] o_cycles,
    dma_xfer_ctrl_if.master        dma
);

    state_t                 r_state;
    logic [ADDR_WIDTH-1:0]  r_src;
    logic [ADDR_WIDTH-1:0]  r_dst;
    logic [SIZE_WIDTH-1:0]  r_size;
    logic [SIZE_WIDTH-1:0]  r_rd_cnt;
    logic [SIZE_WIDTH-1:0]  r_wr_cnt;
    logic                   r_done;
    logic                   r_busy;
    logic [CYCLE_WIDTH-1:0] r_cycles;
    logic                   r_rd_fin;
    logic                   r_wr_fin;

    logic                   w_in_xfer;
    logic                   w_valid;
    logic [DATA_WIDTH-1:0]  w_data;
    logic                   w_wr_fire;
    logic                   w_rd_en;
    logic [SIZE_WIDTH-1:0]  w_wr_cnt_nxt;
    logic                   w_can_go;

    always_comb begin
        w_in_xfer    = (r_state == ST_XFER);
        w_can_go     = (r_state == ST_IDLE) || (r_state == ST_DONE);
        w_wr_fire    = w_in_xfer && w_valid && !dma.dma_full;
        // Pop only when the stage is free now or drains this same cycle.
        w_rd_en      = w_in_xfer && !dma.dma_empty && (r_rd_cnt < r_size) &&
                       (!w_valid || w_wr_fire);
        w_wr_cnt_nxt = r_wr_cnt + SIZE_WIDTH'(w_wr_fire);
    end

    dma_xfer_stage #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_ld    (w_rd_en),
        .i_clr   (w_wr_fire),
        .i_data  (dma.dma_rd_data),
        .o_valid (w_valid),
        .o_data  (w_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_src    <= '0;
            r_dst    <= '0;
            r_size   <= '0;
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_cycles <= '0;
            r_rd_fin <= 1'b0;
            r_wr_fin <= 1'b0;
        end else begin
            if (r_busy && (r_cycles != '1)) begin
                r_cycles <= r_cycles + CYCLE_WIDTH'(1);
            end
            if (w_rd_en) begin
                r_rd_cnt <= r_rd_cnt + SIZE_WIDTH'(1);
            end
            r_wr_cnt <= w_wr_cnt_nxt;
            // Completion flags are sticky so the two done strobes may arrive in any order.
            if (!w_can_go) begin
                r_rd_fin <= r_rd_fin || dma.dma_rd_done;
                r_wr_fin <= r_wr_fin || dma.dma_wr_done;
            end

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_go) begin
                        r_src    <= i_src_addr;
                        r_dst    <= i_dst_addr;
                        r_size   <= i_size;
                        r_rd_cnt <= '0;
                        r_wr_cnt <= '0;
                        r_cycles <= '0;
                        r_rd_fin <= 1'b0;
                        r_wr_fin <= 1'b0;
                        r_done   <= (i_size == '0);
                        r_busy   <= (i_size != '0);
                        r_state  <= (i_size == '0) ? ST_DONE : ST_START;
                    end
                end
                ST_START: r_state <= ST_XFER;
                ST_XFER: begin
                    if (w_wr_cnt_nxt == r_size) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if ((r_rd_fin || dma.dma_rd_done) && (r_wr_fin || dma.dma_wr_done)) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_done           = r_done;
    assign o_busy           = r_busy;
    assign o_cycles         = r_cycles;
    assign dma.dma_rd_go    = (r_state == ST_START);
    assign dma.dma_wr_go    = (r_state == ST_START);
    assign dma.dma_rd_addr  = r_src;
    assign dma.dma_wr_addr  = r_dst;
    assign dma.dma_rd_size  = r_size;
    assign dma.dma_wr_size  = r_size;
    assign dma.dma_rd_en    = w_rd_en;
    assign dma.dma_wr_en    = w_wr_fire;
    assign dma.dma_wr_data  = w_data;

endmodule

// File: tb/tb_dma_xfer_ctrl.sv
// Self-checking bench for dma_xfer_ctrl: stream models, scoreboard queue and a vector table.
module tb_dma_xfer_ctrl;

    localparam int unsigned DW = 512;
    localparam int unsigned AW = 64;
    localparam int unsigned SW = 17;
    localparam int unsigned CW = 32;

    typedef struct {
        int          size;
        int          full_mode;
        int          empty_mode;
        int          wr_gap;
        logic [63:0] src;
        logic [63:0] dst;
        int          exp_done_at;
        int          exp_lag;
    } vec_t;

    logic          clk;
    logic          rst_n;
    logic          go;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [SW-1:0] size;
    logic          done;
    logic          busy;
    logic [CW-1:0] cycles;

    dma_xfer_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW)) dma_bus ();

    dma_xfer_ctrl #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .SIZE_WIDTH  (SW),
        .CYCLE_WIDTH (CW)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_go       (go),
        .i_src_addr (src_addr),
        .i_dst_addr (dst_addr),
        .i_size     (size),
        .o_done     (done),
        .o_busy     (busy),
        .o_cycles   (cycles),
        .dma        (dma_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int go_cyc, xfer_size, full_mode, empty_mode, wr_gap;
    int n_rd, n_wr, n_rdgo, n_wrgo, n_busy, first_rd, first_wr, rd_fin_cyc, wr_pulse_cyc;
    bit xfer_on = 1'b0;
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] exp_q[$];
    vec_t vecs[6];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] mk_line(input int n);
        logic [DW-1:0] l;
        for (int k = 0; k < int'(DW / 32); k++) begin
            l[k*32 +: 32] = 32'(n * 7919 + k) ^ 32'hA5A5_0000;
        end
        return l;
    endfunction

    // One clock: drive stream inputs after negedge, then observe what the next posedge commits.
    task automatic tick();
        @(negedge clk);
        cyc++;
        dma_bus.dma_full    = (full_mode == 1) && ((cyc % 2) == 1);
        dma_bus.dma_empty   = (src_q.size() == 0) || ((empty_mode == 1) && ((cyc % 3) == 0));
        dma_bus.dma_rd_data = (src_q.size() != 0) ? src_q[0] : '0;
        dma_bus.dma_rd_done = xfer_on && (xfer_size != 0) && (n_rd == xfer_size);
        if (dma_bus.dma_rd_done && rd_fin_cyc < 0) rd_fin_cyc = cyc;
        if (wr_gap == 0) begin
            dma_bus.dma_wr_done = xfer_on && (xfer_size != 0) && (n_wr == xfer_size);
        end else begin
            dma_bus.dma_wr_done = xfer_on && (rd_fin_cyc >= 0) && (cyc == rd_fin_cyc + wr_gap);
        end
        if (dma_bus.dma_wr_done && wr_pulse_cyc < 0) wr_pulse_cyc = cyc;
        #2;
        if (rst_n) begin
            if (dma_bus.dma_rd_go) n_rdgo++;
            if (dma_bus.dma_wr_go) n_wrgo++;
            if (busy) n_busy++;
            if (dma_bus.dma_rd_en) begin
                check("rd_en_while_empty", dma_bus.dma_empty, 1'b0);
                if (src_q.size() != 0) void'(src_q.pop_front());
                if (first_rd < 0) first_rd = cyc;
                n_rd++;
            end
            if (dma_bus.dma_wr_en) begin
                check("wr_en_while_full", dma_bus.dma_full, 1'b0);
                check("wr_has_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) check("wr_data", dma_bus.dma_wr_data, exp_q.pop_front());
                if (first_wr < 0) first_wr = cyc;
                n_wr++;
            end
        end
    endtask

    task automatic start_xfer(input int sz, input logic [63:0] s, input logic [63:0] d,
                              input int seed);
        for (int i = 0; i < sz; i++) begin
            src_q.push_back(mk_line(seed + i));
            exp_q.push_back(mk_line(seed + i));
        end
        xfer_size = sz; xfer_on = 1'b1;
        n_rd = 0; n_wr = 0; n_rdgo = 0; n_wrgo = 0; n_busy = 0;
        first_rd = -1; first_wr = -1; rd_fin_cyc = -1; wr_pulse_cyc = -1;
        dma_bus.dma_rd_done = 1'b0;
        dma_bus.dma_wr_done = 1'b0;
        src_addr = s; dst_addr = d; size = SW'(sz);
        go = 1'b1;
        go_cyc = cyc;
        tick();
        go = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int at);
        int t = 0;
        while (!done && t < budget) begin
            tick();
            t++;
        end
        if (!done) check("done_timeout", done, 1'b1);
        at = cyc - go_cyc;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_cycles"}, cycles, '0);
        check({tag, "_rd_go"}, dma_bus.dma_rd_go, 1'b0);
        check({tag, "_wr_go"}, dma_bus.dma_wr_go, 1'b0);
        check({tag, "_rd_en"}, dma_bus.dma_rd_en, 1'b0);
        check({tag, "_wr_en"}, dma_bus.dma_wr_en, 1'b0);
        check({tag, "_rd_addr"}, dma_bus.dma_rd_addr, '0);
        check({tag, "_wr_addr"}, dma_bus.dma_wr_addr, '0);
        check({tag, "_rd_size"}, dma_bus.dma_rd_size, '0);
        check({tag, "_wr_size"}, dma_bus.dma_wr_size, '0);
        check({tag, "_wr_data"}, dma_bus.dma_wr_data, '0);
    endtask

    task automatic run_vec(input vec_t v, input int seed);
        int at;
        full_mode = v.full_mode; empty_mode = v.empty_mode; wr_gap = v.wr_gap;
        start_xfer(v.size, v.src, v.dst, seed);
        check("rd_go_first", dma_bus.dma_rd_go, v.size != 0);
        check("wr_go_first", dma_bus.dma_wr_go, v.size != 0);
        check("rd_addr", dma_bus.dma_rd_addr, v.src);
        check("wr_addr", dma_bus.dma_wr_addr, v.dst);
        check("rd_size", dma_bus.dma_rd_size, SW'(v.size));
        check("wr_size", dma_bus.dma_wr_size, SW'(v.size));
        wait_done(500, at);
        check("n_writes", n_wr, v.size);
        check("n_reads", n_rd, v.size);
        check("scoreboard_empty", exp_q.size(), 0);
        check("n_rd_go", n_rdgo, v.size != 0);
        check("n_wr_go", n_wrgo, v.size != 0);
        check("busy_at_done", busy, 1'b0);
        check("cycles", cycles, n_busy);
        if (v.exp_done_at != 0) check("done_latency", at, v.exp_done_at);
        if (v.exp_lag != 0) begin
            check("first_rd_cycle", first_rd - go_cyc, 2);
            check("wr_lag", first_wr - first_rd, v.exp_lag);
        end
        if (v.wr_gap != 0) check("done_after_wr_done", go_cyc + at - wr_pulse_cyc, 1);
        tick(); tick();
        check("done_held", done, 1'b1);
        check("cycles_frozen", cycles, n_busy);
    endtask

    initial begin
        int at;
        vecs[0] = '{4, 0, 0, 0,  64'h1000, 64'h8000, 8, 1};
        vecs[1] = '{8, 1, 0, 0,  64'h2000, 64'h9000, 0, 0};
        vecs[2] = '{0, 0, 0, 0,  64'h3000, 64'hA000, 1, 0};
        vecs[3] = '{1, 0, 0, 0,  64'h4000, 64'hB000, 5, 1};
        vecs[4] = '{5, 1, 1, 0,  64'h5000, 64'hC000, 0, 0};
        vecs[5] = '{6, 0, 0, 10, 64'h6000, 64'hD000, 0, 0};

        rst_n = 1'b0; go = 1'b0; src_addr = '0; dst_addr = '0; size = '0;
        dma_bus.dma_rd_data = '0; dma_bus.dma_empty = 1'b1; dma_bus.dma_rd_done = 1'b0;
        dma_bus.dma_full = 1'b0; dma_bus.dma_wr_done = 1'b0;
        full_mode = 0; empty_mode = 0; wr_gap = 0; xfer_size = 0;
        n_rd = 0; n_wr = 0; n_rdgo = 0; n_wrgo = 0; n_busy = 0;
        first_rd = -1; first_wr = -1; rd_fin_cyc = -1; wr_pulse_cyc = -1;
        tick(); tick();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_vec(vecs[i], 100 * (i + 1));

        // go pulsed mid-transfer must be ignored
        full_mode = 0; empty_mode = 0; wr_gap = 0;
        start_xfer(6, 64'h7000, 64'hE000, 900);
        tick(); tick();
        go = 1'b1; src_addr = 64'hDEAD; dst_addr = 64'hBEEF; size = SW'(3);
        tick();
        go = 1'b0;
        check("ign_rd_addr", dma_bus.dma_rd_addr, 64'h7000);
        check("ign_wr_addr", dma_bus.dma_wr_addr, 64'hE000);
        check("ign_rd_size", dma_bus.dma_rd_size, SW'(6));
        check("ign_wr_size", dma_bus.dma_wr_size, SW'(6));
        wait_done(200, at);
        check("ign_n_writes", n_wr, 6);
        check("ign_n_rd_go", n_rdgo, 1);
        check("ign_scoreboard", exp_q.size(), 0);
        check("ign_cycles", cycles, n_busy);

        // synchronous reset in the middle of a 16-line copy
        start_xfer(16, 64'h1234, 64'h5678, 1200);
        for (int t = 0; t < 50 && n_rd < 5; t++) tick();
        check("rst_reached_5_lines", n_rd >= 5, 1'b1);
        rst_n = 1'b0;
        tick();
        check_idle_outputs("midrst");
        rst_n = 1'b1;
        xfer_on = 1'b0; src_q.delete(); exp_q.delete();
        n_rdgo = 0; n_wrgo = 0; n_rd = 0; n_wr = 0;
        for (int t = 0; t < 4; t++) tick();
        check("post_rst_no_rd_go", n_rdgo, 0);
        check("post_rst_no_rd_en", n_rd, 0);
        check("post_rst_no_wr_en", n_wr, 0);
        run_vec('{3, 0, 0, 0, 64'h4444, 64'h8888, 7, 1}, 1500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
